// File: rtl/mip_pkg.sv
// mip_pkg: shared image-pipeline geometry, FSM encoding and filter constants
//   MIP_IMG_W / MIP_IMG_H / MIP_DW : default frame geometry and pixel width
//   MIP_XW / MIP_YW                : widths of the column / row coordinates
//   MIP_TAPS                       : taps in a 3x3 filter window
//   win_state_e                    : window generator FSM states
package mip_pkg;
  localparam int MIP_IMG_W = 640;
  localparam int MIP_IMG_H = 480;
  localparam int MIP_DW = 8;
  localparam int MIP_XW = 10;
  localparam int MIP_YW = 9;
  localparam int MIP_TAPS = 9;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DONE} win_state_e;
endpackage

// File: rtl/line_ram.sv
// line_ram: simple dual-port DEPTH x DW RAM with registered read
//   clk             : write and read clock
//   we/wr_addr/wr_data : write port
//   rd_addr         : read address, data appears on rd_data one cycle later
//   rd_data         : read data (old contents on a same-address write)
module line_ram #(
  parameter int DEPTH = 640,
  parameter int DW = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/line_window_3x3.sv
// line_window_3x3: raster pixel stream to zero-padded 3x3 neighbourhood windows
//   clk, rst_n      : clock, asynchronous active-low reset
//   enable          : high runs a frame, low aborts to idle
//   in_valid/in_data/in_ready : pixel input handshake, ready only while running
//   win_valid/win   : 3x3 window, row-major, [DW-1:0] top-left
//   win_x/win_y     : window centre coordinates
//   done            : one-cycle pulse after the last window of a frame
module line_window_3x3
  import mip_pkg::*;
#(
  parameter int IMG_W = MIP_IMG_W,
  parameter int IMG_H = MIP_IMG_H,
  parameter int DW = MIP_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              in_ready,
  output logic              win_valid,
  output logic [9*DW-1:0]   win,
  output logic [9:0]        win_x,
  output logic [8:0]        win_y,
  output logic              done
);
  localparam int AW = $clog2(IMG_W);
  localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
  localparam logic [8:0] Y_LAST = 9'(IMG_H - 1);
  localparam logic [9:0] FL_LAST = 10'(IMG_W);
  win_state_e state_q, state_d;
  logic [9:0] col_q, col_d, cx_q, cx_d, fl_q, fl_d, win_x_q, win_x_d;
  logic [8:0] row_q, row_d, cy_q, cy_d, win_y_q, win_y_d;
  logic win_valid_q, win_valid_d, done_q, done_d;
  logic [8:0][DW-1:0] taps_q, taps_d;
  logic [DW-1:0] lb0_rd, lb1_rd, pix;
  logic acc, shift, primed, emit, last_px;
  // lb0 holds the previous line, lb1 the line before it; both are read one
  // cycle ahead at the next stream column so data is ready on acceptance
  line_ram #(.DEPTH(IMG_W), .DW(DW)) u_lb0 (
    .clk(clk), .we(shift), .wr_addr(col_q[AW-1:0]), .wr_data(pix),
    .rd_addr(col_d[AW-1:0]), .rd_data(lb0_rd)
  );
  line_ram #(.DEPTH(IMG_W), .DW(DW)) u_lb1 (
    .clk(clk), .we(shift), .wr_addr(col_q[AW-1:0]), .wr_data(lb0_rd),
    .rd_addr(col_d[AW-1:0]), .rd_data(lb1_rd)
  );
  always_comb begin
    acc = state_q == ST_RUN && enable && in_valid;
    shift = acc || (state_q == ST_FLUSH && enable);
    pix = acc ? in_data : '0;
    // stream index has reached IMG_W+1: every further pixel completes a window
    primed = state_q == ST_FLUSH || row_q > 9'd1 || (row_q == 9'd1 && col_q != '0);
    emit = shift && primed;
    last_px = col_q == X_LAST && row_q == Y_LAST;
    state_d = !enable ? ST_IDLE :
              state_q == ST_IDLE ? ST_RUN :
              state_q == ST_RUN ? (acc && last_px ? ST_FLUSH : ST_RUN) :
              state_q == ST_FLUSH ? (fl_q == FL_LAST ? ST_DONE : ST_FLUSH) : ST_IDLE;
    col_d = !shift ? col_q : col_q == X_LAST ? '0 : col_q + 10'd1;
    row_d = !(acc && col_q == X_LAST) ? row_q : row_q == Y_LAST ? '0 : row_q + 9'd1;
    fl_d = state_q == ST_FLUSH ? fl_q + 10'd1 : fl_q;
    cx_d = !emit ? cx_q : cx_q == X_LAST ? '0 : cx_q + 10'd1;
    cy_d = !(emit && cx_q == X_LAST) ? cy_q : cy_q == Y_LAST ? '0 : cy_q + 9'd1;
    if (state_d == ST_IDLE) begin
      col_d = '0;
      row_d = '0;
      fl_d = '0;
      cx_d = '0;
      cy_d = '0;
    end
    win_valid_d = emit;
    win_x_d = emit ? cx_q : win_x_q;
    win_y_d = emit ? cy_q : win_y_q;
    done_d = state_q == ST_DONE && enable;
    // shift left, new right column is {two lines up, one line up, current}
    taps_d = shift ? {pix, taps_q[8:7], lb0_rd, taps_q[5:4], lb1_rd, taps_q[2:1]} : taps_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      col_q <= '0;
      row_q <= '0;
      fl_q <= '0;
      cx_q <= '0;
      cy_q <= '0;
      win_x_q <= '0;
      win_y_q <= '0;
      win_valid_q <= 1'b0;
      done_q <= 1'b0;
      taps_q <= '0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      fl_q <= fl_d;
      cx_q <= cx_d;
      cy_q <= cy_d;
      win_x_q <= win_x_d;
      win_y_q <= win_y_d;
      win_valid_q <= win_valid_d;
      done_q <= done_d;
      taps_q <= taps_d;
    end
  end
  // border taps read zero, which also hides stale line-buffer contents
  always_comb
    for (int i = 0; i < 9; i++)
      win[i*DW +: DW] = ((i % 3 == 0 && win_x_q == '0) || (i % 3 == 2 && win_x_q == X_LAST) ||
                         (i < 3 && win_y_q == '0) || (i > 5 && win_y_q == Y_LAST)) ? '0 : taps_q[i];
  assign in_ready = state_q == ST_RUN && enable;
  assign win_valid = win_valid_q;
  assign win_x = win_x_q;
  assign win_y = win_y_q;
  assign done = done_q;
endmodule

// File: tb/tb_line_window_3x3.sv
// tb_line_window_3x3: scoreboard bench with a zero-padded window reference model
module tb_line_window_3x3;
  localparam int W = 4;
  localparam int H = 3;
  localparam int DW = 8;
  typedef struct packed {
    logic [9*DW-1:0] w;
    logic [9:0] x;
    logic [8:0] y;
  } exp_t;
  typedef int nine_t [9];
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, win_valid, done;
  logic [9*DW-1:0] win;
  logic [9:0] win_x;
  logic [8:0] win_y;
  exp_t exp_q[$];
  logic [9*DW-1:0] got [H][W];
  int pix [H][W];
  int n_pass = 0;
  int n_tot = 0;
  int ph = 0;
  int sn = 0;
  bit ev = 1'b0;
  bit ed = 1'b0;
  always #5 clk = ~clk;
  line_window_3x3 #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .win_valid(win_valid), .win(win), .win_x(win_x), .win_y(win_y),
    .done(done)
  );
  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [71:0] pk(input nine_t v);
    logic [71:0] r;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = 8'(v[i]);
    return r;
  endfunction
  // protocol-level model: phase and stream index predict the next cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      ph = 0;
      sn = 0;
      ev = 1'b0;
      ed = 1'b0;
    end else begin
      chk("in_ready", in_ready, ph == 1 && enable);
      chk("win_valid", win_valid, ev);
      chk("done", done, ed);
      if (win_valid) begin
        if (exp_q.size() == 0) begin
          n_tot++;
          $display("FAIL unexpected_window: got x=%0d y=%0d expected none", win_x, win_y);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("win", win, e.w);
          chk("win_x", win_x, e.x);
          chk("win_y", win_y, e.y);
        end
        if (int'(win_y) < H && int'(win_x) < W) got[int'(win_y)][int'(win_x)] = win;
      end
      ev = 1'b0;
      ed = 1'b0;
      if (!enable) begin
        ph = 0;
        sn = 0;
      end else if (ph == 0) ph = 1;
      else if (ph == 1) begin
        if (in_valid) begin
          ev = sn >= W + 1;
          sn++;
          if (sn == W * H) ph = 2;
        end
      end else if (ph == 2) begin
        ev = 1'b1;
        sn++;
        if (sn == W * H + W + 1) ph = 3;
      end else begin
        ed = 1'b1;
        ph = 0;
      end
    end
  end
  task automatic load_frame(input bit ramp);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        pix[y][x] = ramp ? y * W + x + 1 : int'($urandom_range(0, 255));
        got[y][x] = '0;
      end
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        exp_t e;
        e.x = 10'(x);
        e.y = 9'(y);
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) begin
            int yy = y + r - 1;
            int xx = x + c - 1;
            e.w[(r*3+c)*DW +: DW] = (yy >= 0 && yy < H && xx >= 0 && xx < W) ? DW'(pix[yy][xx]) : '0;
          end
        exp_q.push_back(e);
      end
  endtask
  task automatic send(input bit gaps, input int stop_at);
    enable = 1'b1;
    for (int i = 0; i < W * H && i != stop_at; i++) begin
      int t = 0;
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 2)) tick();
      end
      in_valid = 1'b1;
      in_data = DW'(pix[i / W][i % W]);
      while (!in_ready && t < 20) begin
        tick();
        t++;
      end
      if (!in_ready) begin
        n_tot++;
        $display("FAIL handshake_timeout: got in_ready=0 expected 1 within 20 cycles");
        in_valid = 1'b0;
        return;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask
  task automatic finish_frame(input bit ramp);
    repeat (W + 6) tick();
    chk("queue_empty", exp_q.size(), 0);
    if (ramp) begin
      chk("ramp_c11", got[1][1], pk('{1, 2, 3, 5, 6, 7, 9, 10, 11}));
      chk("ramp_c00", got[0][0], pk('{0, 0, 0, 0, 1, 2, 0, 5, 6}));
      chk("ramp_c32", got[2][3], pk('{7, 8, 0, 11, 12, 0, 0, 0, 0}));
    end
    exp_q.delete();
    enable = 1'b0;
    repeat (2) tick();
  endtask
  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_win_valid"}, win_valid, 0);
    chk({tag, "_win"}, win, 0);
    chk({tag, "_win_x"}, win_x, 0);
    chk({tag, "_win_y"}, win_y, 0);
    chk({tag, "_done"}, done, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) tick();
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    tick();
    load_frame(1'b1);
    send(1'b0, -1);
    finish_frame(1'b1);
    load_frame(1'b1);
    send(1'b1, -1);
    finish_frame(1'b1);
    load_frame(1'b1);
    send(1'b0, 6);
    enable = 1'b0;
    repeat (3) tick();
    exp_q.delete();
    load_frame(1'b1);
    send(1'b0, -1);
    finish_frame(1'b1);
    load_frame(1'b0);
    send(1'b1, -1);
    finish_frame(1'b0);
    load_frame(1'b1);
    send(1'b0, -1);
    tick();
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("flush_reset");
    exp_q.delete();
    enable = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (W + 6) tick();
    load_frame(1'b0);
    send(1'b0, -1);
    finish_frame(1'b0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
